dcache_ctrl: RTL

- Direct-mapped, write-back, write-allocate data cache with its own controller FSM.
- Sits between the pipeline's memory stage and a pipelined main-memory port; replaces the flat data memory inside proc_hier.
- Produces the done, stall, cache_hit and cache_req signals that the pipeline and the hierarchy perf bench consume.
- Holds tag, valid, dirty and data arrays in flops.

---
 rtl/dcache_pkg.sv | 30 +++
 rtl/dcache_ctrl_if.sv | 22 ++
 rtl/dcache_array.sv | 52 +++++
 rtl/dcache.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the direct-mapped write-back data cache.
// Field widths below match the default geometry of 32 lines of 4 words.
package dcache_pkg;

    localparam int TAG_W = 8;
    localparam int IDX_W = 5;
    localparam int OFF_W = 2;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WB,
        ALLOC,
        FILL
    } state_t;

    // Helpers return 16-bit values so callers can size them to their own index width
    function automatic logic [15:0] addr_tag(input logic [15:0] a, input int idx_w);
        return a >> (OFF_W + 1 + idx_w);
    endfunction

    function automatic logic [15:0] addr_idx(input logic [15:0] a, input int idx_w);
        return (a >> (OFF_W + 1)) & ((16'd1 << idx_w) - 16'd1);
    endfunction

    function automatic logic [OFF_W-1:0] addr_word(input logic [15:0] a);
        return a[OFF_W:1];
    endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// Pipelined main-memory port between the data cache (master) and memory (slave).
interface dcache_ctrl_if;

    logic        mem_req;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;

    modport master (
        output mem_req, mem_wr, mem_addr, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_wr, mem_addr, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/dcache_array.sv
// Tag, valid, dirty and data storage for the cache: one combinational read port,
// one full-line write port. Only valid/dirty are reset; data and tags are don't-care when invalid.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int LINES = 32,
    parameter int WORDS = 4,
    parameter int TW    = TAG_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [$clog2(LINES)-1:0]    rd_idx,
    output logic [TW-1:0]               rd_tag,
    output logic                        rd_valid,
    output logic                        rd_dirty,
    output logic [WORDS-1:0][15:0]      rd_line,
    input  logic                        we,
    input  logic [$clog2(LINES)-1:0]    wr_idx,
    input  logic [TW-1:0]               wr_tag,
    input  logic                        wr_dirty,
    input  logic [WORDS-1:0][15:0]      wr_line
);

    logic [TW-1:0]          tag_mem   [LINES];
    logic [WORDS-1:0][15:0] data_mem  [LINES];
    logic [LINES-1:0]       valid_bits;
    logic [LINES-1:0]       dirty_bits;

    // Every write installs a live line, so valid is set unconditionally on we
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_bits <= '0;
            dirty_bits <= '0;
        end else if (we) begin
            valid_bits[wr_idx] <= 1'b1;
            dirty_bits[wr_idx] <= wr_dirty;
        end
    end

    always_ff @(posedge clk) begin
        if (we && !rst) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_line;
        end
    end

    assign rd_tag   = tag_mem[rd_idx];
    assign rd_line  = data_mem[rd_idx];
    assign rd_valid = valid_bits[rd_idx];
    assign rd_dirty = dirty_bits[rd_idx];

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache controller: request latch,
// hit/miss FSM, writeback and line-fill sequencing over a pipelined memory port.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES = 32,
    parameter int WORDS = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd,
    input  logic          wr,
    input  logic [15:0]   addr,
    input  logic [15:0]   data_in,
    output logic [15:0]   data_out,
    output logic          done,
    output logic          stall,
    output logic          cache_hit,
    output logic          cache_req,
    output logic          err,
    dcache_ctrl_if.master mem
);

    localparam int IW = $clog2(LINES);
    localparam int TW = 16 - IW - OFF_W - 1;

    state_t                 state, next_state;
    logic [TW-1:0]          req_tag;
    logic [IW-1:0]          req_idx;
    logic [OFF_W-1:0]       req_word;
    logic [15:0]            req_data;
    logic                   req_store;
    logic [2:0]             issue_cnt, resp_cnt;
    logic [WORDS-1:0][15:0] fill_buf, fill_line, store_line;
    logic                   err_q;

    logic [TW-1:0]          rd_tag;
    logic                   rd_valid, rd_dirty;
    logic [WORDS-1:0][15:0] rd_line, wr_line;
    logic                   we, wr_dirty;

    logic                   accept, bad_req, hit, issue_fire, rsp_take;
    logic                   mem_req_c, mem_wr_c;
    logic [15:0]            mem_addr_c, mem_wdata_c;

    dcache_array #(.LINES(LINES), .WORDS(WORDS), .TW(TW)) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (req_idx),
        .rd_tag   (rd_tag),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .rd_line  (rd_line),
        .we       (we),
        .wr_idx   (req_idx),
        .wr_tag   (req_tag),
        .wr_dirty (wr_dirty),
        .wr_line  (wr_line)
    );

    // Requests are held off during the err pulse so err never coincides with cache_req
    assign accept     = (state == IDLE) && !err_q && (rd ^ wr) && !addr[0];
    assign bad_req    = (state == IDLE) && !err_q && ((rd & wr) | ((rd | wr) & addr[0]));
    assign hit        = rd_valid && (rd_tag == req_tag);
    assign issue_fire = mem_req_c && mem.mem_ready;
    assign rsp_take   = (state == ALLOC) && mem.mem_rvalid && (resp_cnt < issue_cnt);

    always_comb begin
        store_line           = rd_line;
        store_line[req_word] = req_data;
        fill_line            = fill_buf;
        if (req_store) begin
            fill_line[req_word] = req_data;
        end
    end

    always_comb begin
        next_state  = state;
        done        = 1'b0;
        cache_hit   = 1'b0;
        cache_req   = 1'b0;
        data_out    = 16'h0000;
        we          = 1'b0;
        wr_dirty    = 1'b0;
        wr_line     = store_line;
        mem_req_c   = 1'b0;
        mem_wr_c    = 1'b0;
        mem_addr_c  = 16'h0000;
        mem_wdata_c = 16'h0000;
        case (state)
            IDLE: begin
                if (accept) begin
                    cache_req  = 1'b1;
                    next_state = COMPARE;
                end
            end
            COMPARE: begin
                if (hit) begin
                    done       = 1'b1;
                    cache_hit  = 1'b1;
                    next_state = IDLE;
                    if (req_store) begin
                        we       = 1'b1;
                        wr_dirty = 1'b1;
                    end else begin
                        data_out = rd_line[req_word];
                    end
                end else if (rd_valid && rd_dirty) begin
                    next_state = WB;
                end else begin
                    next_state = ALLOC;
                end
            end
            WB: begin
                mem_req_c   = 1'b1;
                mem_wr_c    = 1'b1;
                mem_addr_c  = {rd_tag, req_idx, issue_cnt[1:0], 1'b0};
                mem_wdata_c = rd_line[issue_cnt[1:0]];
                if (mem.mem_ready && issue_cnt == 3'd3) begin
                    next_state = ALLOC;
                end
            end
            ALLOC: begin
                if (issue_cnt < 3'd4) begin
                    mem_req_c  = 1'b1;
                    mem_addr_c = {req_tag, req_idx, issue_cnt[1:0], 1'b0};
                end
                if (rsp_take && resp_cnt == 3'd3) begin
                    next_state = FILL;
                end
            end
            FILL: begin
                we         = 1'b1;
                wr_dirty   = req_store;
                wr_line    = fill_line;
                done       = 1'b1;
                next_state = IDLE;
                if (!req_store) begin
                    data_out = fill_line[req_word];
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Issue counter is reused by WB then ALLOC, so it wraps to 0 on the last writeback
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            err_q     <= 1'b0;
            issue_cnt <= 3'd0;
            resp_cnt  <= 3'd0;
            req_tag   <= '0;
            req_idx   <= '0;
            req_word  <= '0;
            req_data  <= 16'h0000;
            req_store <= 1'b0;
            fill_buf  <= '0;
        end else begin
            state <= next_state;
            err_q <= bad_req;
            if (accept) begin
                req_tag   <= TW'(addr_tag(addr, IW));
                req_idx   <= IW'(addr_idx(addr, IW));
                req_word  <= addr_word(addr);
                req_data  <= data_in;
                req_store <= wr;
            end
            if (issue_fire) begin
                issue_cnt <= (state == WB && issue_cnt == 3'd3) ? 3'd0 : issue_cnt + 3'd1;
            end
            if (rsp_take) begin
                fill_buf[resp_cnt[1:0]] <= mem.mem_rdata;
                resp_cnt                <= resp_cnt + 3'd1;
            end
            if (state == FILL) begin
                issue_cnt <= 3'd0;
                resp_cnt  <= 3'd0;
            end
        end
    end

    assign stall         = (state != IDLE);
    assign err           = err_q;
    assign mem.mem_req   = mem_req_c;
    assign mem.mem_wr    = mem_wr_c;
    assign mem.mem_addr  = mem_addr_c;
    assign mem.mem_wdata = mem_wdata_c;

endmodule
